// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencing controller: scoreboard slot layout,
// controller FSM states and the hard-wired zero register index.
package pipe_ctrl_pkg;

  typedef struct packed {
    logic       valid;
    logic       fp;
    logic [4:0] rd;
  } sb_entry_t;

  typedef enum logic {
    RUN       = 1'b0,
    CTRL_WAIT = 1'b1
  } ctrl_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_cmp.sv
// Compares one ID source operand against one in-flight scoreboard slot.
module hazard_cmp
  import pipe_ctrl_pkg::*;
(
  input  logic       src_i,
  input  logic [4:0] src_idx_i,
  input  logic       src_fp_i,
  input  sb_entry_t  entry_i,
  output logic       hit_o
);

  // GPR r0 is hard-wired, so it can never be waiting on a producer; f0 is a real register.
  logic src_is_r0;
  assign src_is_r0 = ~src_fp_i & (src_idx_i == REG_ZERO);

  assign hit_o = src_i & ~src_is_r0 & entry_i.valid
               & (entry_i.fp == src_fp_i) & (entry_i.rd == src_idx_i);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline sequencer: RAW interlock against an EX/MEM/WB destination
// scoreboard, post-branch IF/ID flush window, and whole-pipe freeze on mem_wait.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CTRL_SHADOW      = 3,
  parameter int RF_WRITE_THROUGH = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic        id_rs1_fp,
  input  logic        id_rs1_used,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs2_fp,
  input  logic        id_rs2_used,
  input  logic [4:0]  id_rd,
  input  logic        id_rd_fp,
  input  logic        id_rd_write,
  input  logic        id_ctrl,
  input  logic        mem_wait,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        pipe_freeze,
  output logic        ctrl_busy,
  output logic [15:0] stall_count
);

  // With a write-through register file the WB slot is already readable in ID.
  localparam logic [2:0] SLOT_MASK = (RF_WRITE_THROUGH != 0) ? 3'b011 : 3'b111;

  sb_entry_t   ex_q, mem_q, wb_q, ex_d;
  ctrl_state_t state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  sb_entry_t   slot_w [3];
  logic [2:0]  hit_rs1, hit_rs2;
  logic        freeze, flush_now, raw, issue;

  assign slot_w[0] = ex_q;
  assign slot_w[1] = mem_q;
  assign slot_w[2] = wb_q;

  for (genvar g = 0; g < 3; g++) begin : g_slot
    hazard_cmp u_cmp_rs1 (
      .src_i     (id_rs1_used),
      .src_idx_i (id_rs1),
      .src_fp_i  (id_rs1_fp),
      .entry_i   (slot_w[g]),
      .hit_o     (hit_rs1[g])
    );
    hazard_cmp u_cmp_rs2 (
      .src_i     (id_rs2_used),
      .src_idx_i (id_rs2),
      .src_fp_i  (id_rs2_fp),
      .entry_i   (slot_w[g]),
      .hit_o     (hit_rs2[g])
    );
  end

  assign freeze    = mem_wait;
  assign flush_now = (state_q == CTRL_WAIT);
  // ID only carries flushed NOPs during the shadow, so nothing there can hazard.
  assign raw       = id_valid & ~flush_now & (|((hit_rs1 | hit_rs2) & SLOT_MASK));
  assign issue     = id_valid & ~raw & ~freeze & ~flush_now;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;
    ctrl_busy   = 1'b0;
    if (freeze) begin
      pipe_freeze = 1'b1;
    end else if (flush_now) begin
      ifid_flush = 1'b1;
      ctrl_busy  = 1'b1;
    end else if (raw) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_bubble = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!freeze) begin
      case (state_q)
        RUN: begin
          if (issue && id_ctrl) begin
            state_d = CTRL_WAIT;
            cnt_d   = 3'(CTRL_SHADOW);
          end
        end
        CTRL_WAIT: begin
          if (cnt_q == 3'd1) begin
            state_d = RUN;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    ex_d.valid = issue & id_rd_write & ~(~id_rd_fp & (id_rd == REG_ZERO));
    ex_d.fp    = id_rd_fp;
    ex_d.rd    = id_rd;
    stall_cnt_d = stall_cnt_q;
    if (raw && !freeze && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      state_q     <= RUN;
      cnt_q       <= 3'd0;
      stall_cnt_q <= 16'd0;
    end else if (!freeze) begin
      wb_q        <= mem_q;
      mem_q       <= ex_q;
      ex_q        <= ex_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a write-through instance and a
// non-write-through instance share the same stimulus.
module tb_pipe_hazard_ctrl;

  logic        clock;
  logic        reset;
  logic        id_valid, id_rs1_fp, id_rs1_used, id_rs2_fp, id_rs2_used;
  logic        id_rd_fp, id_rd_write, id_ctrl, mem_wait;
  logic [4:0]  id_rs1, id_rs2, id_rd;

  logic        pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze, ctrl_busy;
  logic [15:0] stall_count;
  logic        n_pc_stall, n_ifid_stall, n_ifid_flush, n_idex_bubble, n_pipe_freeze, n_ctrl_busy;
  logic [15:0] n_stall_count;

  int tests = 0;
  int fails = 0;

  // {pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze, ctrl_busy}
  localparam logic [5:0] O_IDLE   = 6'b000000;
  localparam logic [5:0] O_STALL  = 6'b110100;
  localparam logic [5:0] O_FLUSH  = 6'b001001;
  localparam logic [5:0] O_FREEZE = 6'b000010;

  logic [5:0] outs, n_outs;
  assign outs   = {pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze, ctrl_busy};
  assign n_outs = {n_pc_stall, n_ifid_stall, n_ifid_flush, n_idex_bubble, n_pipe_freeze, n_ctrl_busy};

  pipe_hazard_ctrl #(.CTRL_SHADOW(3), .RF_WRITE_THROUGH(1)) dut (
    .clock(clock), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs1_fp(id_rs1_fp), .id_rs1_used(id_rs1_used),
    .id_rs2(id_rs2), .id_rs2_fp(id_rs2_fp), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_rd_fp(id_rd_fp), .id_rd_write(id_rd_write),
    .id_ctrl(id_ctrl), .mem_wait(mem_wait),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .pipe_freeze(pipe_freeze), .ctrl_busy(ctrl_busy),
    .stall_count(stall_count)
  );

  pipe_hazard_ctrl #(.CTRL_SHADOW(3), .RF_WRITE_THROUGH(0)) dut_nwt (
    .clock(clock), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs1_fp(id_rs1_fp), .id_rs1_used(id_rs1_used),
    .id_rs2(id_rs2), .id_rs2_fp(id_rs2_fp), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_rd_fp(id_rd_fp), .id_rd_write(id_rd_write),
    .id_ctrl(id_ctrl), .mem_wait(mem_wait),
    .pc_stall(n_pc_stall), .ifid_stall(n_ifid_stall), .ifid_flush(n_ifid_flush),
    .idex_bubble(n_idex_bubble), .pipe_freeze(n_pipe_freeze), .ctrl_busy(n_ctrl_busy),
    .stall_count(n_stall_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic clear_inputs();
    id_valid = 0; id_rs1 = 0; id_rs1_fp = 0; id_rs1_used = 0;
    id_rs2 = 0; id_rs2_fp = 0; id_rs2_used = 0;
    id_rd = 0; id_rd_fp = 0; id_rd_write = 0; id_ctrl = 0; mem_wait = 0;
  endtask

  task automatic set_instr(input logic [4:0] rs1, input logic rs1_fp, input logic rs1_used,
                           input logic [4:0] rs2, input logic rs2_fp, input logic rs2_used,
                           input logic [4:0] rd, input logic rd_fp, input logic rd_write,
                           input logic ctrl);
    id_valid = 1;
    id_rs1 = rs1; id_rs1_fp = rs1_fp; id_rs1_used = rs1_used;
    id_rs2 = rs2; id_rs2_fp = rs2_fp; id_rs2_used = rs2_used;
    id_rd = rd; id_rd_fp = rd_fp; id_rd_write = rd_write; id_ctrl = ctrl;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 0;
    next_cycle();
    reset = 1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clock);
    tests++;
    if (outs !== O_IDLE) begin
      fails++; $display("FAIL reset_outs: got %b required %b", outs, O_IDLE);
    end
    tests++;
    if (stall_count !== 16'd0 || n_stall_count !== 16'd0) begin
      fails++; $display("FAIL reset_count: got %0d/%0d required 0", stall_count, n_stall_count);
    end
    next_cycle();
  endtask

  // ADD r1,r2,r3 then SUB r4,r1,r2: 2 bubbles write-through, 3 without.
  task automatic test_raw_basic();
    logic [5:0] exp_o [5];
    logic       exp_nb [5];
    exp_o  = '{O_IDLE, O_STALL, O_STALL, O_IDLE, O_IDLE};
    exp_nb = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      if (c == 0) set_instr(5'd2, 0, 1, 5'd3, 0, 1, 5'd1, 0, 1, 0);
      else        set_instr(5'd1, 0, 1, 5'd2, 0, 1, 5'd4, 0, 1, 0);
      @(negedge clock);
      tests++;
      if (outs !== exp_o[c]) begin
        fails++; $display("FAIL raw_wt_cycle%0d: got %b required %b", c, outs, exp_o[c]);
      end
      tests++;
      if (n_idex_bubble !== exp_nb[c]) begin
        fails++; $display("FAIL raw_nwt_cycle%0d: got %b required %b", c, n_idex_bubble, exp_nb[c]);
      end
      next_cycle();
    end
    clear_inputs();
    @(negedge clock);
    tests++;
    if (stall_count !== 16'd2) begin
      fails++; $display("FAIL raw_wt_count: got %0d required 2", stall_count);
    end
    tests++;
    if (n_stall_count !== 16'd3) begin
      fails++; $display("FAIL raw_nwt_count: got %0d required 3", n_stall_count);
    end
    next_cycle();
  endtask

  // r0 writes and GPR/FPR mismatches never stall; f0 does.
  task automatic test_no_hazard();
    do_reset();
    set_instr(5'd5, 0, 1, 5'd6, 0, 1, 5'd0, 0, 1, 0);   // writes r0
    next_cycle();
    set_instr(5'd0, 0, 1, 5'd0, 0, 1, 5'd3, 0, 1, 0);   // reads r0, writes r3
    @(negedge clock);
    tests++;
    if (outs !== O_IDLE || n_outs !== O_IDLE) begin
      fails++; $display("FAIL r0_read: got %b/%b required %b", outs, n_outs, O_IDLE);
    end
    next_cycle();
    set_instr(5'd3, 1, 1, 5'd0, 0, 1, 5'd0, 1, 1, 0);   // reads f3, writes f0
    @(negedge clock);
    tests++;
    if (outs !== O_IDLE || n_outs !== O_IDLE) begin
      fails++; $display("FAIL fpr_vs_gpr: got %b/%b required %b", outs, n_outs, O_IDLE);
    end
    next_cycle();
    set_instr(5'd9, 0, 0, 5'd0, 1, 1, 5'd8, 0, 1, 0);   // reads f0
    @(negedge clock);
    tests++;
    if (outs !== O_STALL) begin
      fails++; $display("FAIL f0_hazard: got %b required %b", outs, O_STALL);
    end
    clear_inputs();
    next_cycle();
  endtask

  // BEQZ r7 issues: 3 flush cycles, then a normal issue that is tracked.
  task automatic test_ctrl_flush();
    do_reset();
    set_instr(5'd7, 0, 1, 5'd0, 0, 0, 5'd0, 0, 0, 1);
    @(negedge clock);
    tests++;
    if (outs !== O_IDLE) begin
      fails++; $display("FAIL ctrl_issue: got %b required %b", outs, O_IDLE);
    end
    next_cycle();
    clear_inputs();
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      tests++;
      if (outs !== O_FLUSH) begin
        fails++; $display("FAIL ctrl_flush_cycle%0d: got %b required %b", c, outs, O_FLUSH);
      end
      next_cycle();
    end
    set_instr(5'd7, 0, 1, 5'd0, 0, 0, 5'd6, 0, 1, 0);   // ADD r6 fetched at +4
    @(negedge clock);
    tests++;
    if (outs !== O_IDLE) begin
      fails++; $display("FAIL ctrl_after: got %b required %b", outs, O_IDLE);
    end
    next_cycle();
    set_instr(5'd6, 0, 1, 5'd0, 0, 0, 5'd2, 0, 1, 0);
    @(negedge clock);
    tests++;
    if (outs !== O_STALL) begin
      fails++; $display("FAIL ctrl_after_tracked: got %b required %b", outs, O_STALL);
    end
    clear_inputs();
    next_cycle();
  endtask

  // Freeze in the middle of a RAW stall keeps the remaining bubble count.
  task automatic test_freeze_in_stall();
    do_reset();
    set_instr(5'd2, 0, 1, 5'd3, 0, 1, 5'd1, 0, 1, 0);
    next_cycle();
    set_instr(5'd1, 0, 1, 5'd2, 0, 1, 5'd4, 0, 1, 0);
    @(negedge clock);
    tests++;
    if (outs !== O_STALL) begin
      fails++; $display("FAIL frz_first_bubble: got %b required %b", outs, O_STALL);
    end
    next_cycle();
    mem_wait = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      tests++;
      if (outs !== O_FREEZE || stall_count !== 16'd1) begin
        fails++; $display("FAIL frz_hold_cycle%0d: got %b cnt %0d required %b cnt 1",
                          c, outs, stall_count, O_FREEZE);
      end
      next_cycle();
    end
    mem_wait = 0;
    @(negedge clock);
    tests++;
    if (outs !== O_STALL) begin
      fails++; $display("FAIL frz_resume_bubble: got %b required %b", outs, O_STALL);
    end
    next_cycle();
    @(negedge clock);
    tests++;
    if (outs !== O_IDLE || stall_count !== 16'd2) begin
      fails++; $display("FAIL frz_issue: got %b cnt %0d required %b cnt 2", outs, stall_count, O_IDLE);
    end
    clear_inputs();
    next_cycle();
  endtask

  // Reset pulled in cycle 2 of CTRL_WAIT clears everything immediately.
  task automatic test_reset_mid_ctrl();
    do_reset();
    set_instr(5'd2, 0, 1, 5'd3, 0, 1, 5'd1, 0, 1, 0);
    next_cycle();
    set_instr(5'd1, 0, 1, 5'd0, 0, 0, 5'd0, 0, 0, 1);   // BEQZ r1, stalls twice
    next_cycle();
    next_cycle();
    next_cycle();
    clear_inputs();
    @(negedge clock);
    tests++;
    if (outs !== O_FLUSH || stall_count !== 16'd2) begin
      fails++; $display("FAIL rst_pre: got %b cnt %0d required %b cnt 2", outs, stall_count, O_FLUSH);
    end
    next_cycle();
    #2;
    reset = 0;
    #1;
    tests++;
    if (outs !== O_IDLE || stall_count !== 16'd0) begin
      fails++; $display("FAIL rst_async: got %b cnt %0d required %b cnt 0", outs, stall_count, O_IDLE);
    end
    next_cycle();
    reset = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      tests++;
      if (outs !== O_IDLE || stall_count !== 16'd0) begin
        fails++; $display("FAIL rst_release_cycle%0d: got %b cnt %0d required %b cnt 0",
                          c, outs, stall_count, O_IDLE);
      end
      next_cycle();
    end
  endtask

  initial begin
    reset = 0;
    clear_inputs();
    test_reset();
    test_raw_basic();
    test_no_hazard();
    test_ctrl_flush();
    test_freeze_in_stall();
    test_reset_mid_ctrl();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
